// File: rtl/usb_rst_sequencer_pkg.sv
// Shared types and constants for the USB reset sequencer.
// CTRL bit layout depends on the optional USB_RST_IRQ_EN build macro.
package usb_rst_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Register addresses
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PULSE  = 2'd1;
    localparam logic [1:0] ADDR_WAIT   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CTRL write bits
    localparam int CTRL_START = 0;
    localparam int CTRL_FORCE = 1;
    // CTRL read bits
    localparam int CTRL_BUSY  = 0;
`ifdef USB_RST_IRQ_EN
    localparam int CTRL_IE    = 2;
    localparam int CTRL_DONE  = 3;
`else
    localparam int CTRL_DONE  = 2;
`endif
    // STATUS write bit
    localparam int STATUS_CLR = 0;

    // Counter load value for a programmed cycle count; 0 is treated as 1.
    function automatic logic [31:0] cnt_load(input logic [31:0] cycles);
        return (cycles == 32'd0) ? 32'd0 : cycles - 32'd1;
    endfunction

endpackage

// File: rtl/usb_rst_sequencer_if.sv
// Avalon-MM slave bus bundle for the USB reset sequencer.
interface usb_rst_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/usb_rst_sequencer_timer.sv
// Loadable down-counter shared by the pulse and settle phases.
// Holds at zero once it gets there; load has priority over decrement.
module usb_rst_timer #(
    parameter int              CNT_W   = 24,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    assign zero = (count == '0);

    // Count register: load, else decrement while enabled and non-zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (en && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/usb_rst_sequencer.sv
// USB host controller reset sequencer: Avalon-MM register block that drives
// the chip's active-low RES pin with a timed pulse followed by a settle time.
// Optional build macro USB_RST_IRQ_EN adds the irq output and CTRL.IE bit.
module usb_rst_sequencer
    import usb_rst_pkg::*;
#(
    parameter int               CNT_W         = 24,
    parameter logic [CNT_W-1:0] PULSE_DEFAULT = 24'd50000,
    parameter logic [CNT_W-1:0] WAIT_DEFAULT  = 24'd100000,
    parameter bit               AUTO_START    = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    usb_rst_sequencer_if.slave  bus,
    output logic                usb_rst_n,
    output logic                busy
`ifdef USB_RST_IRQ_EN
    ,
    output logic                irq
`endif
);

    // With AUTO_START the block leaves reset already in the pulse phase.
    localparam state_t           ST_RST  = AUTO_START ? ASSERT : IDLE;
    localparam logic [CNT_W-1:0] TMR_RST = AUTO_START ? CNT_W'(cnt_load(32'(PULSE_DEFAULT))) : '0;

    state_t           state, next_state;
    logic [CNT_W-1:0] pulse_cyc, wait_cyc, count, load_val;
    logic             load, en, zero;
    logic             done, done_nxt, force_q, force_nxt;
    logic             wr, wr_ctrl, start_ok, clr;
    logic [31:0]      rdata;
    logic             unused_wdata;

    assign unused_wdata = ^bus.writedata;

    assign wr        = bus.chipselect && !bus.write_n;
    assign wr_ctrl   = wr && (bus.address == ADDR_CTRL);
    assign start_ok  = wr_ctrl && bus.writedata[CTRL_START] && (state == IDLE);
    assign clr       = wr && (bus.address == ADDR_STATUS) && bus.writedata[STATUS_CLR];
    assign force_nxt = wr_ctrl ? bus.writedata[CTRL_FORCE] : force_q;
    assign busy      = (state != IDLE);

`ifdef USB_RST_IRQ_EN
    logic ie, ie_nxt;
    assign ie_nxt = wr_ctrl ? bus.writedata[CTRL_IE] : ie;
`endif

    usb_rst_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (TMR_RST)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .count    (count),
        .zero     (zero)
    );

    // Next-state and timer control
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_val   = '0;
        en         = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    next_state = ASSERT;
                    load       = 1'b1;
                    load_val   = CNT_W'(cnt_load(32'(pulse_cyc)));
                end
            end
            ASSERT: begin
                if (zero) begin
                    next_state = SETTLE;
                    load       = 1'b1;
                    load_val   = CNT_W'(cnt_load(32'(wait_cyc)));
                end else begin
                    en = 1'b1;
                end
            end
            SETTLE: begin
                if (zero) next_state = IDLE;
                else      en = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // DONE: end of settle wins over a simultaneous clear
    always_comb begin
        done_nxt = done;
        if (state == SETTLE && zero) done_nxt = 1'b1;
        else if (start_ok || clr)    done_nxt = 1'b0;
    end

    // State, registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RST;
            usb_rst_n <= 1'b0;
            done      <= 1'b0;
            force_q   <= 1'b0;
            pulse_cyc <= PULSE_DEFAULT;
            wait_cyc  <= WAIT_DEFAULT;
`ifdef USB_RST_IRQ_EN
            ie        <= 1'b0;
            irq       <= 1'b0;
`endif
        end else begin
            state     <= next_state;
            usb_rst_n <= !((next_state == ASSERT) || force_nxt);
            done      <= done_nxt;
            force_q   <= force_nxt;
            if (wr && bus.address == ADDR_PULSE) pulse_cyc <= bus.writedata[CNT_W-1:0];
            if (wr && bus.address == ADDR_WAIT)  wait_cyc  <= bus.writedata[CNT_W-1:0];
`ifdef USB_RST_IRQ_EN
            ie        <= ie_nxt;
            irq       <= done_nxt && ie_nxt;
`endif
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_CTRL: begin
                rdata[CTRL_BUSY]  = busy;
                rdata[CTRL_FORCE] = force_q;
                rdata[CTRL_DONE]  = done;
`ifdef USB_RST_IRQ_EN
                rdata[CTRL_IE]    = ie;
`endif
            end
            ADDR_PULSE:  rdata[CNT_W-1:0] = pulse_cyc;
            ADDR_WAIT:   rdata[CNT_W-1:0] = wait_cyc;
            ADDR_STATUS: rdata[CNT_W-1:0] = count;
            default:     rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;

endmodule

// File: doc/usb_rst_sequencer.md
Name: usb_rst_sequencer

Overview:
- Avalon-MM slave controller that drives the USB host controller's active-low reset pin with a timed pulse.
- Software can also hold reset manually.
- Replaces bit-banging of a bare output-port register: the NIOS writes a start bit and polls `busy`/`done` instead of timing the pulse in firmware.
- Sits on the SoC's peripheral bus beside the USB SPI master and drives the chip's RES pin.

Parameters:
- CNT_W, 24: width of the pulse and settle counters and of the timing registers.
- PULSE_DEFAULT, 24'd50000: reset value of PULSE_CYC (1 ms at 50 MHz).
- WAIT_DEFAULT, 24'd100000: reset value of WAIT_CYC (2 ms settle).
- AUTO_START, 1: 1 = run one reset sequence automatically after `reset_n` deasserts.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data (combinational from `address`)
- usb_rst_n  out  1  registered active-low reset to the USB chip
- busy  out  1  sequence in progress (ASSERT or SETTLE)

Behaviour:
- Register map. A write is `chipselect && !write_n`.
  - 0 CTRL. Write: bit0 START (pulse, not stored); bit1 FORCE (stored). Read: bit0 busy, bit1 FORCE, bit2 DONE.
  - 1 PULSE_CYC. R/W, `writedata[CNT_W-1:0]`; upper bits are ignored and read back as 0.
  - 2 WAIT_CYC. R/W, same width rule as PULSE_CYC.
  - 3 STATUS. Write bit0 = 1 clears DONE. Read: `{8'b0, remaining count}` zero-extended.
- Unused read bits are 0. Readdata has no wait states and is purely combinational on `address`.
- Reset values:
  - `usb_rst_n` = 0 (chip held in reset while `reset_n` is low); FORCE = 0; DONE = 0.
  - PULSE_CYC = PULSE_DEFAULT; WAIT_CYC = WAIT_DEFAULT.
  - State = ASSERT with counter = PULSE_DEFAULT-1 if AUTO_START, else IDLE.
- FSM (state register, with `usb_rst_n` registered from next-state):
  - IDLE: `usb_rst_n` = ~FORCE; busy = 0. START write at cycle T → ASSERT at T+1, counter loaded with `max(PULSE_CYC,1)-1`, DONE cleared.
  - ASSERT: `usb_rst_n` = 0; busy = 1. When counter == 0, go to SETTLE and load `max(WAIT_CYC,1)-1`; else decrement. `usb_rst_n` is low for exactly `max(PULSE_CYC,1)` cycles.
  - SETTLE: `usb_rst_n` = ~FORCE; busy = 1. When counter == 0, go to IDLE and set DONE; else decrement. SETTLE lasts exactly `max(WAIT_CYC,1)` cycles.
- Latency: START written at cycle T gives `usb_rst_n` low from T+1. DONE reads 1 at cycle `T+1+P+W`, where P and W are the effective (≥1) counts.
- Boundary rules:
  - START while busy is ignored; the sequence is not restarted.
  - Writes to PULSE_CYC/WAIT_CYC while busy update the registers only. The running count is unaffected; new values apply from the next START.
  - Value 0 in either register behaves as 1.
  - FORCE = 1 overrides `usb_rst_n` to 0 in every state. The FSM still sequences normally, and `busy`/DONE behave as without FORCE.
  - START and DONE-clear in the same cycle (different addresses cannot coincide): N/A. If SETTLE finishes in the same cycle as a DONE-clear write, set wins.
  - `reset_n` asserted mid-sequence: immediate asynchronous return to the reset values above. With AUTO_START, the sequence restarts from the beginning after release.

Optional Feature:
- USB_RST_IRQ_EN. When defined:
  - Adds output port `irq` (1 bit, registered, reset 0) and CTRL bit2 IE (write/read, reset 0).
  - `irq` = DONE & IE; it deasserts when DONE is cleared via STATUS.
  - CTRL read bit2 becomes IE, and DONE moves to bit3.
- When undefined: no `irq` port, no IE bit; DONE stays at bit2.

Decomposition:
- Package `usb_rst_pkg`:
  - State enum {IDLE, ASSERT, SETTLE}.
  - Register address constants (CTRL, PULSE, WAIT, STATUS).
  - CTRL/STATUS bit-index constants.
- Sub-module `usb_rst_timer`: loadable CNT_W down-counter with `load`, `load_val`, `en`, `zero` outputs. The FSM instantiates it once.

Test Plan:
- AUTO_START = 1, PULSE_DEFAULT = 4, WAIT_DEFAULT = 3; release `reset_n` → `usb_rst_n` low 4 cycles after release, then high; busy falls and DONE = 1 exactly 7 cycles after release.
- Write PULSE = 5, WAIT = 2, then CTRL = 0x1 at cycle T → `usb_rst_n` = 0 for T+1..T+5, high at T+6; DONE set at T+8; STATUS read during ASSERT shows the decrementing count.
- START again at T+3 of a running sequence → timing identical to a single sequence (no restart). Then write STATUS = 1 → DONE reads 0.
- Write PULSE = 0, WAIT = 0, START → `usb_rst_n` low exactly 1 cycle; DONE after 2 cycles.
- CTRL = 0x2 (FORCE) in IDLE → `usb_rst_n` = 0 next cycle and stays 0 through a START/SETTLE sequence; CTRL = 0x0 → `usb_rst_n` = 1.
- Assert `reset_n` mid-SETTLE → `usb_rst_n` = 0, registers return to defaults, DONE = 0. With USB_RST_IRQ_EN and IE = 1, `irq` = 1 after DONE and 0 after STATUS write 0x1.
